weight_delta_gen: RTL and testbench

Sequential delta generator that produces the `delta` and `sign` operands consumed by the weight-update stage.
- Takes one (target, actual, learning-rate) sample via a valid/ready handshake.
- Computes error = target - actual and scales |error| by the learning rate with an iterative shift-add multiplier.
- Returns a saturated unsigned delta plus a direction bit via a second valid/ready handshake.
- Sits between the neuron output/error path and the combinational weight updater.

---
 rtl/weight_delta_gen_if.sv | 28 ++
 rtl/weight_delta_gen.sv | 113 +++++++++++
 tb/tb_weight_delta_gen.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/weight_delta_gen_if.sv
// weight_delta_gen_if: sample/result handshake bundle for weight_delta_gen.
//   in_valid/in_ready + target/actual/lr : sample into the block
//   out_valid/out_ready + delta/sign     : result out of the block
// master = producer/consumer side (testbench or neighbour stages),
// slave  = the delta generator itself.
interface weight_delta_gen_if #(
    parameter int W = 10
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] target;
    logic [W-1:0] actual;
    logic [W-1:0] lr;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] delta;
    logic         sign;

    modport master (
        output in_valid, target, actual, lr, out_ready,
        input  in_ready, out_valid, delta, sign
    );

    modport slave (
        input  in_valid, target, actual, lr, out_ready,
        output in_ready, out_valid, delta, sign
    );
endinterface

// File: rtl/weight_delta_gen.sv
// weight_delta_gen: sequential delta generator for the weight-update stage.
// Accepts one (target, actual, lr) sample, forms err = target - actual,
// scales |err| by lr with a W-cycle shift-add multiplier, drops FRAC
// fractional bits (truncate), saturates to W bits and returns the
// magnitude plus a direction bit (1 = weight must decrease).
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : weight_delta_gen_if.slave (sample in, delta/sign out)
module weight_delta_gen #(
    parameter int W    = 10,
    parameter int FRAC = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    weight_delta_gen_if.slave bus
);
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

    state_t          state_q, state_d;
    logic            sign_r_q, sign_r_d;
    logic [W:0]      mag_q, mag_d;
    logic [W-1:0]    lr_q, lr_d;
    logic [2*W:0]    acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    delta_q, delta_d;
    logic            sign_q, sign_d;

    logic            in_ready, out_valid;
    logic [W:0]      err;
    logic [2*W:0]    p;

    // Sign-extended difference in W+1 bits cannot overflow.
    assign err = {bus.target[W-1], bus.target} - {bus.actual[W-1], bus.actual};
    assign p   = acc_q >> FRAC;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sign_r_q <= 1'b0;
            mag_q    <= '0;
            lr_q     <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            delta_q  <= '0;
            sign_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sign_r_q <= sign_r_d;
            mag_q    <= mag_d;
            lr_q     <= lr_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            delta_q  <= delta_d;
            sign_q   <= sign_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sign_r_d  = sign_r_q;
        mag_d     = mag_q;
        lr_d      = lr_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        delta_d   = delta_q;
        sign_d    = sign_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    sign_r_d = err[W];
                    mag_d    = err[W] ? (~err + 1'b1) : err;
                    lr_d     = bus.lr;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = MUL;
                end
            end
            MUL: begin
                // One multiplier bit per cycle, LSB first; no early exit so
                // latency is constant.
                if (lr_q[cnt_q])
                    acc_d = acc_q + ({{W{1'b0}}, mag_q} << cnt_q);
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1))
                    state_d = NORM;
            end
            NORM: begin
                if (|p[2*W:W]) delta_d = '1;
                else           delta_d = p[W-1:0];
                // A zero error never asks for a decrease.
                sign_d  = sign_r_q & (mag_q != '0);
                state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (bus.out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.delta     = delta_q;
    assign bus.sign      = sign_q;
endmodule

// File: tb/tb_weight_delta_gen.sv
// Scoreboard bench for weight_delta_gen: the driver pushes hand-computed
// results (and the cycle out_valid must first rise) when a sample is
// accepted; a negedge monitor pops and compares on each output handshake.
module tb_weight_delta_gen;
    localparam int W = 10;

    typedef struct {
        logic [W-1:0] d;
        logic         s;
        int           rise;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    logic prev_v = 1'b0;

    weight_delta_gen_if #(.W(W)) bus ();

    weight_delta_gen #(.W(W), .FRAC(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: first-rise latency and result comparison on handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v = 1'b0;
        end else begin
            if (bus.out_valid && !prev_v) begin
                if (q.size() == 0) check("unexpected_out_valid", 1, 0);
                else               check("latency", cyc, q[0].rise);
            end
            if (bus.out_valid && bus.out_ready && q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                check("delta", int'(bus.delta), int'(e.d));
                check("sign", int'(bus.sign), int'(e.s));
            end
            prev_v = bus.out_valid;
        end
    end

    // Present a sample, wait (bounded) for acceptance, record expectation.
    // Acceptance edge follows the negedge where cyc=N; the IDLE cycle counts
    // as cycle 0, so out_valid must first be seen at cyc=N+12.
    task automatic send(input int t, input int a, input int l, input int d, input int s);
        int n = 0;
        exp_t e;
        @(negedge clk);
        bus.target   = t[W-1:0];
        bus.actual   = a[W-1:0];
        bus.lr       = l[W-1:0];
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            check("accept_timeout", 0, 1);
        end else begin
            e.d = d[W-1:0];
            e.s = s[0];
            e.rise = cyc + 12;
            q.push_back(e);
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!(q.size() == 0 && bus.in_ready) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0 || !bus.in_ready) check("idle_timeout", 0, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.target    = '0;
        bus.actual    = '0;
        bus.lr        = '0;
        bus.out_ready = 1'b1;

        // Reset state
        #1;
        check("rst_in_ready", int'(bus.in_ready), 1);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_delta", int'(bus.delta), 0);
        check("rst_sign", int'(bus.sign), 0);
        #22 rst_n = 1'b1;

        // Main function: error 50 * 0.5, -300 * 1.0
        send(100, 50, 32, 25, 0);
        send(-100, 200, 64, 300, 1);
        // Saturation both directions
        send(511, -512, 1023, 1023, 0);
        send(-512, 511, 1023, 1023, 1);
        // Truncation and zero cases
        send(3, 0, 10, 0, 0);
        send(77, 77, 500, 0, 0);
        send(0, 40, 0, 0, 1);
        send(-5, 5, 100, 15, 1);
        wait_idle();

        // Backpressure plus input toggling while busy: err 50, lr 1.5 -> 75
        bus.out_ready = 1'b0;
        send(20, -30, 96, 75, 0);
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.target   = W'($urandom);
            bus.actual   = W'($urandom);
            bus.lr       = W'($urandom);
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        begin
            int n = 0;
            while (!bus.out_valid && n < 50) begin
                @(negedge clk);
                n++;
            end
            check("bp_reach_done", int'(bus.out_valid), 1);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid", int'(bus.out_valid), 1);
            check("bp_delta", int'(bus.delta), 75);
            check("bp_sign", int'(bus.sign), 0);
            check("bp_in_ready", int'(bus.in_ready), 0);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("post_hs_out_valid", int'(bus.out_valid), 0);
        check("post_hs_in_ready", int'(bus.in_ready), 1);
        check("post_hs_delta_held", int'(bus.delta), 75);

        // Reset in the middle of MUL discards the sample
        send(100, -100, 64, 200, 0);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        q.delete();
        #1;
        check("midrst_in_ready", int'(bus.in_ready), 1);
        check("midrst_out_valid", int'(bus.out_valid), 0);
        check("midrst_delta", int'(bus.delta), 0);
        check("midrst_sign", int'(bus.sign), 0);
        #12 rst_n = 1'b1;
        send(100, 50, 32, 25, 0);
        send(-60, 60, 128, 240, 1);
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
